sub_seq: RTL and testbench
==========================

// Module: sub_seq
// PURPOSE
//   Multi-cycle wide unsigned subtractor: out = in1 - in2 (mod 2^WIDTH), borrow_out = (in1 < in2).
//   Processes one LIMB-bit slice per clock, propagating the borrow from the low limb upward.
//   Inverse datapath of the team's pipelined wide adder.
//   Used in the big-number arithmetic path behind valid/ready handshakes on both sides.
// PARAMETERS
//   WIDTH  1024  operand/result width in bits; must be a multiple of LIMB (elaboration-time check, $error)
//   LIMB   256   bits subtracted per clock
//   NLIMB  WIDTH/LIMB (localparam, 4) number of limb cycles per operation
// PORTS
//   clk         in   1      single clock, all state on posedge
//   rst_n       in   1      asynchronous, active-low reset
//   in_valid    in   1      operand pair valid
//   in_ready    out  1      block can accept operands
//   in1         in   WIDTH  minuend, unsigned
//   in2         in   WIDTH  subtrahend, unsigned
//   out_valid   out  1      result valid
//   out_ready   in   1      consumer accepts result
//   out         out  WIDTH  difference, registered
//   borrow_out  out  1      final borrow, registered; 1 iff in1 < in2
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, limb counter k=0, internal borrow=0,
//     out=0, borrow_out=0, out_valid=0, operand regs=0; in_ready=1 after release.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//     IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: latch in1/in2 into operand regs,
//       k=0, borrow=0, go RUN.
//     RUN: in_ready=0, out_valid=0. Each cycle, {b,d} = a[k] - b[k] - borrow (LIMB+1-bit unsigned).
//       Write out[k*LIMB +: LIMB]=d; borrow<=b; k<=k+1. When k==NLIMB-1: borrow_out<=b, go DONE.
//     DONE: out_valid=1, in_ready=0; out/borrow_out held stable. On out_ready: go IDLE.
//   Latency: out_valid rises exactly NLIMB cycles after the accepting edge.
//     Throughput is one operation per NLIMB+2 cycles minimum, because no accept happens in DONE.
//   out limbs not yet written in RUN keep their prior values. Consumers sample only when out_valid=1.
//   in1/in2 are sampled only on the accepting edge. Later changes do not affect the result.
//   in_valid is ignored outside IDLE. The upstream side must hold in1/in2/in_valid until in_ready.
//   out_ready is ignored outside DONE. out_valid stays high indefinitely under backpressure.
//   Wrap-around: the result is modulo 2^WIDTH. 0-1 gives all ones with borrow_out=1. x-x gives 0 with borrow_out=0.
//   Reset mid-RUN or mid-DONE aborts the operation: all state returns to reset values immediately.
//     No partial result is presented.
//   Combinational outputs: in_ready and out_valid decode from state only. No in->out combinational path.
// TESTING
//   1 Assert rst_n=0 mid-simulation -> out=0, borrow_out=0, out_valid=0 at once. in_ready=1 after release.
//   2 in1=5, in2=3 -> out=2, borrow_out=0. out_valid high exactly 4 cycles after accept.
//     in_ready=0 through RUN and DONE.
//   3 in1=0, in2=1 -> out={1024{1'b1}}, borrow_out=1. The borrow ripples through all 4 limbs.
//   4 in1=2^256, in2=1 -> out=2^256-1 (limb0 all ones, limbs1-3 zero), borrow_out=0.
//     in1=2^768, in2=2^768 -> out=0, borrow_out=0.
//   5 Hold out_ready=0 for 10 cycles in DONE, toggling in_valid and in1 -> out, borrow_out and out_valid stable.
//     No new accept. The next op is accepted 1 cycle after out_ready.
//   6 Pulse rst_n low during RUN (k=2) -> IDLE, outputs zero, no out_valid.
//     Then random a,b checked against a-b, and (a+b mod 2^1024)-b == a over 1000 vectors.

Source files
------------

// File: rtl/sub_seq.sv
// Multi-cycle wide unsigned subtractor: out = in1 - in2 (mod 2^WIDTH), one LIMB slice per clock,
// borrow rippling from the low limb upward; valid/ready handshakes on both sides.
module sub_seq #(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned LIMB  = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned KW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  if ((WIDTH % LIMB) != 0) begin : g_width_check
    $error("sub_seq: WIDTH (%0d) must be a multiple of LIMB (%0d)", WIDTH, LIMB);
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [KW-1:0]     r_k;
  logic              r_borrow;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_out;
  logic              r_borrow_out;

  logic [LIMB-1:0]   w_limb_a;
  logic [LIMB-1:0]   w_limb_b;
  logic [LIMB:0]     w_diff;
  logic              w_last;

  // The extra top bit of the LIMB+1-bit difference is the borrow into the next limb.
  always_comb begin
    w_limb_a = r_a[r_k*LIMB +: LIMB];
    w_limb_b = r_b[r_k*LIMB +: LIMB];
    w_diff   = {1'b0, w_limb_a} - {1'b0, w_limb_b} - {{LIMB{1'b0}}, r_borrow};
    w_last   = (r_k == KW'(NLIMB - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_borrow     <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_out        <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= in1;
            r_b      <= in2;
            r_k      <= '0;
            r_borrow <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_out[r_k*LIMB +: LIMB] <= w_diff[LIMB-1:0];
          r_borrow                <= w_diff[LIMB];
          if (w_last) begin
            r_borrow_out <= w_diff[LIMB];
            r_k          <= '0;
            r_state      <= S_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out        = r_out;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_sub_seq.sv
// Self-checking bench for sub_seq: directed corner cases, backpressure, reset aborts and
// randomized operands checked against plain wide arithmetic.
module tb_sub_seq;

  localparam int unsigned W = 1024;
  localparam int unsigned L = 256;
  localparam int unsigned N = W / L;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         borrow_out;

  int unsigned n_checks;
  int unsigned n_errors;

  sub_seq #(.WIDTH(W), .LIMB(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs_hi=%h obs_lo=%h exp_hi=%h exp_lo=%h", tag,
               obs[W-1 -: 64], obs[63:0], exp[W-1 -: 64], exp[63:0]);
    end
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int unsigned i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: v = W'($urandom_range(0, 3));
      1: v = '1;
      default: ;
    endcase
    return v;
  endfunction

  // Present operands and wait (bounded) for the accepting edge; returns #1 after it.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned n;
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = rand_wide();
    in2 = rand_wide();
  endtask

  task automatic wait_done(input string tag);
    int unsigned lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid) check({tag, "_run_in_ready"}, W'(in_ready), W'(0));
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, W'(lat), W'(N));
    check({tag, "_done_in_ready"}, W'(in_ready), W'(0));
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", W'(out_valid), W'(0));
    check("release_in_ready", W'(in_ready), W'(1));
  endtask

  task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp_d;
    exp_d = a - b;
    start_op(a, b);
    wait_done(tag);
    check({tag, "_out"}, out, exp_d);
    check({tag, "_borrow"}, W'(borrow_out), W'(a < b));
    finish_op();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"}, out, '0);
    check({tag, "_borrow"}, W'(borrow_out), W'(0));
    check({tag, "_out_valid"}, W'(out_valid), W'(0));
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    in2       = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("por_release_in_ready", W'(in_ready), W'(1));

    op_check("five_minus_three", W'(5), W'(3));
    op_check("zero_minus_one", '0, W'(1));
    a = '0; a[256] = 1'b1;
    op_check("limb_borrow", a, W'(1));
    a = '0; a[768] = 1'b1;
    op_check("equal_high", a, a);

    // Backpressure: result must hold while in_valid/in1 churn and no new accept happens.
    a = rand_wide();
    b = rand_wide();
    s = a - b;
    start_op(a, b);
    wait_done("bp");
    for (int unsigned i = 0; i < 10; i++) begin
      in_valid = i[0];
      in1 = rand_wide();
      @(posedge clk); #1;
      check("bp_out", out, s);
      check("bp_borrow", W'(borrow_out), W'(a < b));
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_in_ready", W'(in_ready), W'(0));
    end
    a = rand_wide();
    b = rand_wide();
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_in_ready", W'(in_ready), W'(1));
    check("bp_idle_out_valid", W'(out_valid), W'(0));
    @(posedge clk); #1;
    check("bp_next_accepted", W'(in_ready), W'(0));
    in_valid = 1'b0;
    in1 = rand_wide();
    wait_done("bp_next");
    check("bp_next_out", out, a - b);
    check("bp_next_borrow", W'(borrow_out), W'(a < b));

    // Reset in DONE.
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_done_release_in_ready", W'(in_ready), W'(1));

    // Reset in RUN with k=2.
    start_op('1, W'(7));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_run");
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_run_no_valid", W'(out_valid), W'(0));
      check("rst_run_in_ready", W'(in_ready), W'(1));
    end

    for (int unsigned i = 0; i < 1000; i++) begin
      a = rand_wide();
      b = (i % 5 == 0) ? a : rand_wide();
      op_check("rand_sub", a, b);
      s = a + b;
      start_op(s, b);
      wait_done("rand_inv");
      check("rand_inv_out", out, a);
      check("rand_inv_borrow", W'(borrow_out), W'(s < b));
      finish_op();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
